// File: rtl/voice_mix_scheduler.sv
// Per-sample voice sequencer: on each sample tick it walks the enabled voices through the
// shared synthesis datapath, sums their samples and emits one saturated mix with a strobe.
module voice_mix_scheduler #(
  parameter int NUM_VOICES = 4,
  parameter int VOICE_W    = 2,
  parameter int SAMPLE_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sample_clock,
  input  logic [NUM_VOICES-1:0] voice_en,
  output logic                  voice_req,
  output logic [VOICE_W-1:0]    voice_idx,
  input  logic                  voice_done,
  input  logic [SAMPLE_W-1:0]   voice_sample,
  output logic [SAMPLE_W-1:0]   mix_out,
  output logic                  mix_valid,
  output logic                  busy,
  output logic                  overrun,
  input  logic                  overrun_clr
);

  localparam int IDX_W = VOICE_W + 1;
  localparam int ACC_W = SAMPLE_W + VOICE_W;
  localparam int EN_W  = 1 << VOICE_W;
  localparam logic [IDX_W-1:0] IDX_END = IDX_W'(NUM_VOICES);

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(VOICE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(VOICE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_WAIT,
    ST_OUTPUT
  } state_t;

  state_t                   state, state_nxt;
  logic                     sc_d;
  logic                     tick;
  logic [EN_W-1:0]          en_q;
  logic [IDX_W-1:0]         idx;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  sample_ext;
  logic [SAMPLE_W-1:0]      sat;
  logic                     cur_en;

  assign tick       = sample_clock & ~sc_d;
  assign sample_ext = {{VOICE_W{voice_sample[SAMPLE_W-1]}}, voice_sample};
  // en_q is padded to a power of two so the low index bits always select a real bit.
  assign cur_en     = en_q[idx[VOICE_W-1:0]];
  assign voice_idx  = idx[VOICE_W-1:0];

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of process ordering in simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (tick) state_nxt = ST_SCAN;
      ST_SCAN: begin
        if (idx == IDX_END)  state_nxt = ST_OUTPUT;
        else if (cur_en)     state_nxt = ST_WAIT;
      end
      ST_WAIT:   if (voice_done) state_nxt = ST_SCAN;
      ST_OUTPUT: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    voice_req = (state == ST_WAIT);
    busy      = (state != ST_IDLE);
  end

  // Clamp only the final sum; the wider accumulator cannot wrap across NUM_VOICES adds.
  always_comb begin
    sat = acc[SAMPLE_W-1:0];
    if (acc > SAT_MAX)      sat = SAT_MAX[SAMPLE_W-1:0];
    else if (acc < SAT_MIN) sat = SAT_MIN[SAMPLE_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sc_d      <= 1'b0;
      en_q      <= '0;
      idx       <= '0;
      acc       <= '0;
      mix_out   <= '0;
      mix_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      sc_d      <= sample_clock;
      mix_valid <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (tick) begin
            en_q <= EN_W'(voice_en);
            acc  <= '0;
            idx  <= '0;
          end
        end
        ST_SCAN: begin
          if (idx != IDX_END && !cur_en) idx <= idx + 1'b1;
        end
        ST_WAIT: begin
          if (voice_done) begin
            acc <= acc + sample_ext;
            idx <= idx + 1'b1;
          end
        end
        ST_OUTPUT: begin
          mix_out   <= sat;
          mix_valid <= 1'b1;
        end
        default: ;
      endcase

      // A tick while busy is dropped but flagged; a new overrun beats a clear.
      if (tick && state != ST_IDLE) overrun <= 1'b1;
      else if (overrun_clr)         overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_voice_mix_scheduler.sv
// Directed bench for voice_mix_scheduler: a responder models the synthesis datapath and
// each sequence is compared with hand-computed mixes, latencies and request orders.
module tb_voice_mix_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sample_clock = 1'b0;
  logic [3:0]  voice_en = 4'b0000;
  logic        voice_req;
  logic [1:0]  voice_idx;
  logic        voice_done = 1'b0;
  logic [15:0] voice_sample = 16'h0000;
  logic [15:0] mix_out;
  logic        mix_valid;
  logic        busy;
  logic        overrun;
  logic        overrun_clr = 1'b0;

  int          n_checks = 0;
  int          n_fail = 0;

  // Datapath model controls
  logic [15:0] samples [4];
  int          stall = 0;
  int          wait_cnt = 0;
  logic        spurious = 1'b0;
  int          req_log [$];

  voice_mix_scheduler #(.NUM_VOICES(4), .VOICE_W(2), .SAMPLE_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_clock(sample_clock),
    .voice_en    (voice_en),
    .voice_req   (voice_req),
    .voice_idx   (voice_idx),
    .voice_done  (voice_done),
    .voice_sample(voice_sample),
    .mix_out     (mix_out),
    .mix_valid   (mix_valid),
    .busy        (busy),
    .overrun     (overrun),
    .overrun_clr (overrun_clr)
  );

  always #5 clk = ~clk;

  // Responder: answers a request after 'stall' extra cycles, or fires stray pulses when asked.
  always @(negedge clk) begin
    voice_done = 1'b0;
    if (voice_req) begin
      if (wait_cnt >= stall) begin
        voice_done   = 1'b1;
        voice_sample = samples[voice_idx];
        req_log.push_back(int'(voice_idx));
        wait_cnt     = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
      if (spurious) begin
        voice_done   = 1'b1;
        voice_sample = 16'h1234;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Rising edge of sample_clock seen at the next posedge (E0); returns at the negedge after E0.
  task automatic tick();
    @(negedge clk) sample_clock = 1'b1;
    @(negedge clk) sample_clock = 1'b0;
  endtask

  // Waits for mix_valid; lat counts posedges after E0. Optionally scrambles voice_en meanwhile.
  task automatic wait_valid(input int max, input bit scramble, output int lat,
                            output logic busy_before, output logic busy_at);
    int n = 0;
    logic prev_busy = busy;
    lat = -1;
    busy_at = 1'bx;
    while (n < max) begin
      @(negedge clk);
      n++;
      if (mix_valid) begin
        lat = n;
        busy_at = busy;
        break;
      end
      prev_busy = busy;
      if (scramble) voice_en = ~voice_en;
    end
    busy_before = prev_busy;
    if (lat < 0) check("mix_valid_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int   lat;
    logic bb, ba;

    // Reset values
    #1;
    check("rst_voice_req", voice_req, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_mix_valid", mix_valid, 1'b0);
    check("rst_mix_out", mix_out, 16'h0000);
    check("rst_overrun", overrun, 1'b0);
    check("rst_voice_idx", voice_idx, 2'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // No voices: strobe 6 cycles after tick, zero mix, no requests
    voice_en = 4'b0000;
    req_log.delete();
    tick();
    wait_valid(50, 1'b0, lat, bb, ba);
    check("empty_latency", lat, 32'd6);
    check("empty_mix", mix_out, 16'h0000);
    check("empty_req_count", req_log.size(), 32'd0);
    check("empty_busy_before", bb, 1'b1);
    check("empty_busy_at_valid", ba, 1'b0);

    // Voices 1 and 3
    samples[0] = 16'd0; samples[1] = 16'd1000; samples[2] = 16'd0; samples[3] = 16'hFED4;
    voice_en = 4'b1010;
    stall = 0;
    req_log.delete();
    tick();
    wait_valid(50, 1'b0, lat, bb, ba);
    check("v13_latency", lat, 32'd8);
    check("v13_mix", mix_out, 16'd700);
    check("v13_req_count", req_log.size(), 32'd2);
    if (req_log.size() == 2) begin
      check("v13_idx0", req_log[0], 32'd1);
      check("v13_idx1", req_log[1], 32'd3);
    end
    check("v13_busy_at_valid", ba, 1'b0);
    @(negedge clk);
    check("v13_valid_one_cycle", mix_valid, 1'b0);
    check("v13_mix_hold", mix_out, 16'd700);

    // Positive saturation
    for (int i = 0; i < 4; i++) samples[i] = 16'h7000;
    voice_en = 4'b1111;
    tick();
    wait_valid(50, 1'b0, lat, bb, ba);
    check("sat_pos_latency", lat, 32'd10);
    check("sat_pos_mix", mix_out, 16'h7FFF);

    // Negative saturation
    for (int i = 0; i < 4; i++) samples[i] = 16'h9000;
    tick();
    wait_valid(50, 1'b0, lat, bb, ba);
    check("sat_neg_mix", mix_out, 16'h8000);

    // Stall on voice 0 with a second tick meanwhile
    samples[0] = 16'd100;
    voice_en = 4'b0001;
    stall = 50;
    req_log.delete();
    tick();
    repeat (10) @(negedge clk);
    check("ovr_pre", overrun, 1'b0);
    sample_clock = 1'b1;
    @(negedge clk) sample_clock = 1'b0;
    check("ovr_set", overrun, 1'b1);
    wait_valid(200, 1'b0, lat, bb, ba);
    check("ovr_mix", mix_out, 16'd100);
    check("ovr_req_count", req_log.size(), 32'd1);
    repeat (10) @(negedge clk);
    check("ovr_no_restart", busy, 1'b0);
    check("ovr_sticky", overrun, 1'b1);

    overrun_clr = 1'b1;
    @(negedge clk) overrun_clr = 1'b0;
    check("ovr_clr", overrun, 1'b0);

    // Clear coincides with a new overrun: set wins
    tick();
    repeat (5) @(negedge clk);
    sample_clock = 1'b1;
    overrun_clr  = 1'b1;
    @(negedge clk);
    sample_clock = 1'b0;
    overrun_clr  = 1'b0;
    check("ovr_set_wins", overrun, 1'b1);
    wait_valid(200, 1'b0, lat, bb, ba);
    overrun_clr = 1'b1;
    @(negedge clk) overrun_clr = 1'b0;

    // Asynchronous reset while in WAIT
    tick();
    for (int i = 0; i < 10 && !voice_req; i++) @(negedge clk);
    check("rstw_in_wait", voice_req, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("rstw_voice_req", voice_req, 1'b0);
    check("rstw_busy", busy, 1'b0);
    check("rstw_mix_valid", mix_valid, 1'b0);
    check("rstw_mix_out", mix_out, 16'h0000);
    @(negedge clk) rst_n = 1'b1;
    stall = 0;
    samples[0] = 16'd5; samples[2] = 16'hFFF9;
    voice_en = 4'b0101;
    req_log.delete();
    tick();
    wait_valid(50, 1'b0, lat, bb, ba);
    check("post_rst_mix", mix_out, 16'hFFFE);
    check("post_rst_req_count", req_log.size(), 32'd2);
    if (req_log.size() == 2) begin
      check("post_rst_idx0", req_log[0], 32'd0);
      check("post_rst_idx1", req_log[1], 32'd2);
    end

    // Stray voice_done in IDLE/SCAN and voice_en churn mid-sequence
    samples[1] = 16'd200; samples[2] = 16'd300;
    stall = 2;
    voice_en = 4'b0110;
    spurious = 1'b1;
    req_log.delete();
    repeat (3) @(negedge clk);
    tick();
    wait_valid(80, 1'b1, lat, bb, ba);
    spurious = 1'b0;
    check("stray_mix", mix_out, 16'd500);
    check("stray_req_count", req_log.size(), 32'd2);
    if (req_log.size() == 2) begin
      check("stray_idx0", req_log[0], 32'd1);
      check("stray_idx1", req_log[1], 32'd2);
    end

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
